// File: rtl/axi_interconnect_width_convert_raddr_if.sv
// rtl/axi_interconnect_width_convert_raddr_if.sv - AXI4 AR channel bundle
// One instance per side; master modport drives the request, slave modport answers with arready.
interface axi_interconnect_width_convert_raddr_if #(
  parameter int WIDTH_ID     = 4,
  parameter int WIDTH_ADDR   = 32,
  parameter int WIDTH_ARUSER = 1
);
  localparam int W_ID   = (WIDTH_ID == 0) ? 1 : WIDTH_ID;
  localparam int W_USER = (WIDTH_ARUSER == 0) ? 1 : WIDTH_ARUSER;

  logic [W_ID-1:0]       arid;
  logic [WIDTH_ADDR-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [11:0]           arside;
  logic [W_USER-1:0]     aruser;
  logic                  arvalid;
  logic                  arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arside, aruser, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arside, aruser, arvalid,
    output arready
  );
endinterface

// File: rtl/axi_interconnect_width_convert_raddr.sv
// rtl/axi_interconnect_width_convert_raddr.sv - AR-channel stage of the AXI4 read width converter
// Rewrites slave ARs for the master width, splits at 256 beats and emits one rresp descriptor per master AR.
module axi_interconnect_width_convert_raddr #(
  parameter int WIDTH_ID          = 4,
  parameter int WIDTH_ADDR        = 32,
  parameter int WIDTH_SDATA       = 32,
  parameter int WIDTH_MDATA       = 32,
  parameter int WIDTH_ARUSER      = 1,
  parameter int WIDTH_OUTSTANDING = 4
) (
  input  logic clk_sys,
  input  logic rst_n,
  axi_interconnect_width_convert_raddr_if.slave  s_ar,
  axi_interconnect_width_convert_raddr_if.master m_ar,
  output logic       req_en,
  output logic [2:0] req_size,
  output logic [7:0] req_offset,
  output logic       req_last,
  input  logic       rsp_done
);
  localparam int SB = $clog2(WIDTH_SDATA / 8);
  localparam int MB = $clog2(WIDTH_MDATA / 8);
  localparam logic [2:0] MB3 = 3'(MB);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, NEXT} state_t;
  state_t state, nstate;

  logic [WIDTH_ADDR-1:0]      c_addr;
  logic [7:0]                 c_len;
  logic [2:0]                 c_size;
  logic [1:0]                 c_burst;
  logic                       c_expand;
  logic [11:0]                remaining;
  logic [WIDTH_OUTSTANDING:0] credits;
  logic [11:0]                total, src, chunk;
  logic [WIDTH_ADDR-1:0]      next_addr;

  assign req_en     = m_ar.arvalid & m_ar.arready;
  assign req_offset = m_ar.araddr[7:0];

  // LOAD sizes the whole burst; NEXT continues from what is still outstanding.
  always_comb begin
    total     = (12'(c_len) + 12'd1) << (c_size - MB3);
    src       = (state == LOAD) ? total : remaining;
    chunk     = (src > 12'd256) ? 12'd256 : src;
    next_addr = (m_ar.araddr & ({WIDTH_ADDR{1'b1}} << c_size))
              + ((WIDTH_ADDR'(m_ar.arlen) + WIDTH_ADDR'(1)) << MB);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (s_ar.arvalid) nstate = LOAD;
      LOAD:    nstate = ISSUE;
      ISSUE:   if (req_en) nstate = (remaining == 12'd0) ? IDLE : NEXT;
      NEXT:    nstate = ISSUE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    s_ar.arready = 1'b0;
    if (state == IDLE) s_ar.arready = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      c_addr       <= '0;
      c_len        <= '0;
      c_size       <= '0;
      c_burst      <= '0;
      c_expand     <= 1'b0;
      remaining    <= '0;
      req_size     <= '0;
      req_last     <= 1'b0;
      m_ar.arid    <= '0;
      m_ar.araddr  <= '0;
      m_ar.arlen   <= '0;
      m_ar.arsize  <= '0;
      m_ar.arburst <= '0;
      m_ar.arside  <= '0;
      m_ar.aruser  <= '0;
      m_ar.arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_ar.arvalid) begin
          c_addr      <= s_ar.araddr;
          c_len       <= s_ar.arlen;
          c_size      <= s_ar.arsize;
          c_burst     <= s_ar.arburst;
          c_expand    <= (SB > MB) && (s_ar.arsize > MB3);
          m_ar.arid   <= (WIDTH_ID == 0) ? '0 : s_ar.arid;
          m_ar.arside <= s_ar.arside;
          m_ar.aruser <= (WIDTH_ARUSER == 0) ? '0 : s_ar.aruser;
        end
        LOAD: begin
          m_ar.araddr <= c_addr;
          // Expanded bursts are always issued as INCR, whatever the slave asked for.
          if (c_expand) begin
            m_ar.arlen   <= 8'(chunk - 12'd1);
            m_ar.arsize  <= MB3;
            m_ar.arburst <= 2'b01;
            remaining    <= src - chunk;
            req_size     <= c_size - MB3;
            req_last     <= (src == chunk);
          end else begin
            m_ar.arlen   <= c_len;
            m_ar.arsize  <= c_size;
            m_ar.arburst <= c_burst;
            remaining    <= 12'd0;
            req_size     <= 3'd0;
            req_last     <= 1'b1;
          end
        end
        ISSUE: begin
          if (!m_ar.arvalid && !credits[WIDTH_OUTSTANDING]) m_ar.arvalid <= 1'b1;
          else if (req_en)                                  m_ar.arvalid <= 1'b0;
        end
        NEXT: begin
          m_ar.araddr <= next_addr;
          m_ar.arlen  <= 8'(chunk - 12'd1);
          remaining   <= src - chunk;
          req_last    <= (src == chunk);
        end
        default: ;
      endcase
    end
  end

  // The top bit of credits set means DEPTH ARs are in flight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      credits <= '0;
    else if (req_en && !rsp_done)
      credits <= credits + {{WIDTH_OUTSTANDING{1'b0}}, 1'b1};
    else if (!req_en && rsp_done && credits != '0)
      credits <= credits - {{WIDTH_OUTSTANDING{1'b0}}, 1'b1};
  end
endmodule

// File: tb/tb_axi_interconnect_width_convert_raddr.sv
// tb/tb_axi_interconnect_width_convert_raddr.sv - directed bench for the AR width converter
// Three instances: 64->32 with 4 credits, 128->32, and 32->64.
module tb_axi_interconnect_width_convert_raddr;
  logic clk_sys = 1'b0;
  logic rst_n;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] s_addr[3];
  logic [7:0]  s_len[3];
  logic [2:0]  s_size[3];
  logic [1:0]  s_burst[3];
  logic [3:0]  s_id[3];
  logic [11:0] s_side[3];
  logic        s_valid[3];
  logic        m_ready[3];
  logic        rsp_done[3];
  logic        r_en[3];
  logic [2:0]  r_size[3];
  logic [7:0]  r_off[3];
  logic        r_last[3];

  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) a_s ();
  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) a_m ();
  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) b_s ();
  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) b_m ();
  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) c_s ();
  axi_interconnect_width_convert_raddr_if #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_ARUSER(1)) c_m ();

  assign a_s.arid = s_id[0];  assign a_s.araddr = s_addr[0];  assign a_s.arlen = s_len[0];
  assign a_s.arsize = s_size[0];  assign a_s.arburst = s_burst[0];  assign a_s.arside = s_side[0];
  assign a_s.aruser = 1'b1;  assign a_s.arvalid = s_valid[0];  assign a_m.arready = m_ready[0];
  assign b_s.arid = s_id[1];  assign b_s.araddr = s_addr[1];  assign b_s.arlen = s_len[1];
  assign b_s.arsize = s_size[1];  assign b_s.arburst = s_burst[1];  assign b_s.arside = s_side[1];
  assign b_s.aruser = 1'b1;  assign b_s.arvalid = s_valid[1];  assign b_m.arready = m_ready[1];
  assign c_s.arid = s_id[2];  assign c_s.araddr = s_addr[2];  assign c_s.arlen = s_len[2];
  assign c_s.arsize = s_size[2];  assign c_s.arburst = s_burst[2];  assign c_s.arside = s_side[2];
  assign c_s.aruser = 1'b1;  assign c_s.arvalid = s_valid[2];  assign c_m.arready = m_ready[2];

  axi_interconnect_width_convert_raddr #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_SDATA(64), .WIDTH_MDATA(32),
    .WIDTH_ARUSER(1), .WIDTH_OUTSTANDING(2)) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .s_ar(a_s), .m_ar(a_m), .req_en(r_en[0]), .req_size(r_size[0]),
    .req_offset(r_off[0]), .req_last(r_last[0]), .rsp_done(rsp_done[0]));
  axi_interconnect_width_convert_raddr #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_SDATA(128), .WIDTH_MDATA(32),
    .WIDTH_ARUSER(1), .WIDTH_OUTSTANDING(4)) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .s_ar(b_s), .m_ar(b_m), .req_en(r_en[1]), .req_size(r_size[1]),
    .req_offset(r_off[1]), .req_last(r_last[1]), .rsp_done(rsp_done[1]));
  axi_interconnect_width_convert_raddr #(.WIDTH_ID(4), .WIDTH_ADDR(32), .WIDTH_SDATA(32), .WIDTH_MDATA(64),
    .WIDTH_ARUSER(1), .WIDTH_OUTSTANDING(4)) dut_c (
    .clk_sys(clk_sys), .rst_n(rst_n), .s_ar(c_s), .m_ar(c_m), .req_en(r_en[2]), .req_size(r_size[2]),
    .req_offset(r_off[2]), .req_last(r_last[2]), .rsp_done(rsp_done[2]));

  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [11:0] side;
    logic        user;
    logic        req_en;
    logic [2:0]  rsz;
    logic [7:0]  off;
    logic        last;
    logic        s_ready;
  } obs_t;

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: o = '{a_m.arvalid, a_m.arid, a_m.araddr, a_m.arlen, a_m.arsize, a_m.arburst, a_m.arside,
               a_m.aruser, r_en[0], r_size[0], r_off[0], r_last[0], a_s.arready};
      1: o = '{b_m.arvalid, b_m.arid, b_m.araddr, b_m.arlen, b_m.arsize, b_m.arburst, b_m.arside,
               b_m.aruser, r_en[1], r_size[1], r_off[1], r_last[1], b_s.arready};
      default: o = '{c_m.arvalid, c_m.arid, c_m.araddr, c_m.arlen, c_m.arsize, c_m.arburst, c_m.arside,
               c_m.aruser, r_en[2], r_size[2], r_off[2], r_last[2], c_s.arready};
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_ar(input int d, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_addr[d] = addr; s_len[d] = len; s_size[d] = size; s_burst[d] = burst; s_valid[d] = 1'b1;
    tick();
    s_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input string tag);
    obs_t o;
    int n = 0;
    o = observe(d);
    while (!o.valid && n < 20) begin
      tick();
      o = observe(d);
      n++;
    end
    check({tag, ".arvalid"}, 32'(o.valid), 32'd1);
  endtask

  task automatic take(input int d, input string tag, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [2:0] rsz,
                      input logic [7:0] off, input logic last);
    obs_t o;
    o = observe(d);
    check({tag, ".addr"},  o.addr, addr);
    check({tag, ".len"},   32'(o.len), 32'(len));
    check({tag, ".size"},  32'(o.size), 32'(size));
    check({tag, ".burst"}, 32'(o.burst), 32'(burst));
    check({tag, ".id"},    32'(o.id), 32'(s_id[d]));
    check({tag, ".side"},  32'(o.side), 32'(s_side[d]));
    check({tag, ".user"},  32'(o.user), 32'd1);
    m_ready[d] = 1'b1;
    #1;
    o = observe(d);
    check({tag, ".req_en"},   32'(o.req_en), 32'd1);
    check({tag, ".req_size"}, 32'(o.rsz), 32'(rsz));
    check({tag, ".req_off"},  32'(o.off), 32'(off));
    check({tag, ".req_last"}, 32'(o.last), 32'(last));
    @(posedge clk_sys);
    #1;
    m_ready[d] = 1'b0;
    o = observe(d);
    check({tag, ".drop"}, {30'd0, o.valid, o.req_en}, 32'd0);
  endtask

  task automatic pulse_done(input int d);
    rsp_done[d] = 1'b1;
    tick();
    rsp_done[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, snap;
    int cnt, diffs;
    for (int d = 0; d < 3; d++) begin
      s_addr[d] = '0; s_len[d] = '0; s_size[d] = '0; s_burst[d] = '0; s_id[d] = '0; s_side[d] = '0;
      s_valid[d] = 1'b0; m_ready[d] = 1'b0; rsp_done[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      o = observe(d);
      check($sformatf("rst%0d.arvalid", d), 32'(o.valid), 32'd0);
      check($sformatf("rst%0d.req_en", d), 32'(o.req_en), 32'd0);
      check($sformatf("rst%0d.req_last", d), 32'(o.last), 32'd0);
      check($sformatf("rst%0d.arlen", d), 32'(o.len), 32'd0);
      check($sformatf("rst%0d.araddr", d), o.addr, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    o = observe(0);
    check("idle.s_arready", 32'(o.s_ready), 32'd1);

    // 64->32 expand: R=2, 8 master beats
    send_ar(0, 32'h100, 8'd3, 3'd3, 2'b01);
    wait_valid(0, "t1");
    take(0, "t1", 32'h100, 8'd7, 3'd2, 2'b01, 3'd1, 8'h00, 1'b1);

    // size equal to master width passes through, burst and side untouched
    s_id[0] = 4'hA; s_side[0] = 12'h5A3;
    send_ar(0, 32'h104, 8'd0, 3'd2, 2'b10);
    wait_valid(0, "t2");
    take(0, "t2", 32'h104, 8'd0, 3'd2, 2'b10, 3'd0, 8'h04, 1'b1);

    // unaligned 512-beat expand of a WRAP: split, second chunk from aligned base, forced INCR
    send_ar(0, 32'h104, 8'd255, 3'd3, 2'b10);
    wait_valid(0, "t3a");
    take(0, "t3a", 32'h104, 8'd255, 3'd2, 2'b01, 3'd1, 8'h04, 1'b0);
    wait_valid(0, "t3b");
    take(0, "t3b", 32'h500, 8'd255, 3'd2, 2'b01, 3'd1, 8'h00, 1'b1);

    // return all 4 credits, plus one extra that must be ignored at zero
    repeat (5) pulse_done(0);
    for (int i = 0; i < 4; i++) begin
      send_ar(0, 32'h200 + 32'(i * 4), 8'd0, 3'd2, 2'b01);
      wait_valid(0, $sformatf("t4_%0d", i));
      take(0, $sformatf("t4_%0d", i), 32'h200 + 32'(i * 4), 8'd0, 3'd2, 2'b01, 3'd0, 8'(i * 4), 1'b1);
    end
    send_ar(0, 32'h300, 8'd1, 3'd2, 2'b01);
    cnt = 0;
    repeat (10) begin
      tick();
      o = observe(0);
      if (o.valid) cnt++;
    end
    check("t4.blocked", 32'(cnt), 32'd0);
    pulse_done(0);
    tick();
    o = observe(0);
    check("t4.resume", 32'(o.valid), 32'd1);

    // hold off the handshake: everything stays put, no descriptor escapes
    snap = observe(0);
    diffs = 0;
    cnt = 0;
    repeat (10) begin
      tick();
      o = observe(0);
      if (o !== snap) diffs++;
      if (o.req_en) cnt++;
    end
    check("t5.stable", 32'(diffs), 32'd0);
    check("t5.no_req", 32'(cnt), 32'd0);
    take(0, "t5", 32'h300, 8'd1, 3'd2, 2'b01, 3'd0, 8'h00, 1'b1);

    // 128->32 expand of 1024 beats: four 256-beat chunks
    send_ar(1, 32'h0, 8'd255, 3'd4, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_valid(1, $sformatf("t6_%0d", k));
      take(1, $sformatf("t6_%0d", k), 32'(k) * 32'h400, 8'd255, 3'd2, 2'b01, 3'd2, 8'h00, (k == 3));
    end
    cnt = 0;
    repeat (5) begin
      tick();
      o = observe(1);
      if (o.valid) cnt++;
    end
    check("t6.no_extra", 32'(cnt), 32'd0);
    check("t6.idle", 32'(o.s_ready), 32'd1);

    // 32->64 upsizing passes through
    send_ar(2, 32'h104, 8'd7, 3'd2, 2'b01);
    wait_valid(2, "t7");
    take(2, "t7", 32'h104, 8'd7, 3'd2, 2'b01, 3'd0, 8'h04, 1'b1);

    // async reset while a master AR is pending
    send_ar(2, 32'h40, 8'd0, 3'd3, 2'b01);
    wait_valid(2, "t8");
    rst_n = 1'b0;
    #1;
    o = observe(2);
    check("t8.rst_arvalid", 32'(o.valid), 32'd0);
    check("t8.rst_req_en", 32'(o.req_en), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
